led_pattern_counter: RTL and testbench
======================================

Name: led_pattern_counter

Overview:
Parametrised LED pattern generator for board bring-up and status display. A runtime-scalable prescaler produces periodic step ticks, and a pattern engine advances on each tick in one of four modes: binary up, binary down, Gray up, or bouncing scanner. It drives the board LED bank directly. It adds enable, load and tick-observability that fixed LED counters lack.

Parameters:
CLK_FREQ, 25_000_000, input clock frequency in Hz
TICK_HZ, 2, base step rate in Hz at speed=0; PERIOD = CLK_FREQ/TICK_HZ, required PERIOD >= 8
LED_WIDTH, 8, number of LEDs, required >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  1 = run; 0 = freeze prescaler and pattern
mode  in  2  00 bin up, 01 bin down, 10 Gray up, 11 scanner
speed  in  2  rate multiplier; effective period EFF = PERIOD >> speed
load  in  1  synchronous load strobe
load_value  in  LED_WIDTH  value loaded into count on load
leds  out  LED_WIDTH  LED drive
tick  out  1  one-cycle pulse on every pattern step

Behaviour:
- Reset: async on rst_n low, no clock needed. Clears prescaler, count, pos and mode_q; dir=up; tick=0; leds=0.
- State registers:
  - prescaler: width clog2(PERIOD)+1
  - count: LED_WIDTH
  - pos: clog2(LED_WIDTH)
  - dir: 1 bit
  - mode_q: 2 bits
  - tick: 1 bit
- Per-edge priority when rst_n is high, highest first:
  1. load=1: count<=load_value; prescaler<=0; pos<=0; dir<=up; mode_q<=mode; tick<=0. Load is honoured even when en=0.
  2. mode!=mode_q: mode_q<=mode; count<=0; pos<=0; dir<=up; prescaler<=0; tick<=0.
  3. en=0: all state holds; tick<=0.
  4. prescaler >= EFF-1: prescaler<=0; tick<=1; pattern steps once.
  5. Otherwise: prescaler+1; tick<=0.
- The >= compare matters when speed increases mid-count: if prescaler is already past the new EFF-1, a tick occurs on the next edge with no overflow or long wait.
- Pattern steps:
  - Modes 00 and 10: count+1, wrapping all-ones -> 0.
  - Mode 01: count-1, wrapping 0 -> all-ones.
  - Mode 11, dir=up: if pos==LED_WIDTH-1, set dir=down and pos-1; else pos+1.
  - Mode 11, dir=down: if pos==0, set dir=up and pos+1; else pos-1.
  - Scanner sequence is 0,1,...,W-1,W-2,...,1,0,1,...; period 2W-2 ticks with no repeated end positions.
- Output decode uses mode_q, never raw mode, so there are no glitches from mode input changes:
  - 00/01: leds=count
  - 10: leds=count ^ (count>>1)
  - 11: leds=1<<pos
- Latency:
  - leds and tick change on the same edge as a step.
  - A load or mode change is visible on leds the cycle after the edge that samples it.
- After a load or mode change, the next tick comes exactly EFF cycles later (en=1, speed constant).
- All arithmetic is unsigned and modulo its register width. PERIOD is computed at elaboration, and the EFF shift is combinational.

Test Plan:
(Bench uses CLK_FREQ=16, TICK_HZ=2, so PERIOD=8.)
1. Release reset, mode=00, speed=0, en=1 -> tick every 8 cycles; leds 0x00,0x01,0x02,...; after 256 ticks leds wraps 0xFF->0x00.
2. Mode 00 at leds 0x05, switch to mode=01 -> next cycle leds=0x00; first tick 8 cycles later gives 0xFF, then 0xFE.
3. Mode=10 -> leds sequence 0x00,0x01,0x03,0x02,0x06,0x07,0x05,0x04 on successive ticks.
4. Mode=11 -> leds 0x01,0x02,0x04,...,0x80,0x40,...,0x01,0x02; period 14 ticks; 0x80 and 0x01 each appear once per sweep.
5. Speed tests:
   - speed=3 (EFF=1) -> tick every cycle.
   - Running at speed=0, change to speed=2 when prescaler=6 -> tick on the next edge; subsequent ticks every 2 cycles.
6. Enable, load and reset:
   - en=0 for 20 cycles -> leds and prescaler frozen, tick=0.
   - load with load_value=0xA5 (mode 00) -> leds=0xA5 next cycle; 0xA6 after exactly 8 cycles.
   - rst_n low between clock edges -> leds=0x00 immediately, before the next edge.

Source files
------------

// File: rtl/led_pattern_counter.sv
// led_pattern_counter: runtime-scalable prescaler stepping a binary up/down, Gray or scanner LED pattern.
module led_pattern_counter #(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int TICK_HZ   = 2,
    parameter int LED_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [1:0]           speed,
    input  logic                 load,
    input  logic [LED_WIDTH-1:0] load_value,
    output logic [LED_WIDTH-1:0] leds,
    output logic                 tick
);
    localparam int PERIOD = CLK_FREQ / TICK_HZ;
    localparam int PW = $clog2(PERIOD) + 1;
    localparam int SW = $clog2(LED_WIDTH);
    localparam logic [PW-1:0] PERIOD_W = PW'(PERIOD);
    localparam logic [SW-1:0] POS_MAX = SW'(LED_WIDTH - 1);
    localparam logic UP = 1'b0;
    logic [PW-1:0]        prescaler, eff_m1;
    logic [LED_WIDTH-1:0] count, count_step;
    logic [SW-1:0]        pos, pos_step;
    logic                 dir, dir_step;
    logic [1:0]           mode_q;
    assign eff_m1 = (PERIOD_W >> speed) - PW'(1);
    // Scanner turns around on the end positions so neither end is shown twice in a row.
    always_comb begin
        count_step = mode_q == 2'b01 ? count - LED_WIDTH'(1) :
                     mode_q == 2'b11 ? count : count + LED_WIDTH'(1);
        dir_step   = mode_q != 2'b11 ? dir : dir ? (pos != '0) : (pos == POS_MAX);
        pos_step   = mode_q != 2'b11 ? pos : dir_step ? pos - SW'(1) : pos + SW'(1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            count     <= '0;
            pos       <= '0;
            dir       <= UP;
            mode_q    <= 2'b00;
            tick      <= 1'b0;
        end else if (load) begin
            prescaler <= '0;
            count     <= load_value;
            pos       <= '0;
            dir       <= UP;
            mode_q    <= mode;
            tick      <= 1'b0;
        end else if (mode != mode_q) begin
            prescaler <= '0;
            count     <= '0;
            pos       <= '0;
            dir       <= UP;
            mode_q    <= mode;
            tick      <= 1'b0;
        end else if (!en) begin
            tick      <= 1'b0;
        end else if (prescaler >= eff_m1) begin
            prescaler <= '0;
            count     <= count_step;
            pos       <= pos_step;
            dir       <= dir_step;
            tick      <= 1'b1;
        end else begin
            prescaler <= prescaler + PW'(1);
            tick      <= 1'b0;
        end
    end
    // Decode from the registered mode so raw mode changes never glitch the LEDs.
    always_comb
        leds = mode_q == 2'b11 ? LED_WIDTH'(1) << pos :
               mode_q == 2'b10 ? count ^ (count >> 1) : count;
endmodule

// File: tb/tb_led_pattern_counter.sv
// tb_led_pattern_counter: table-driven directed checks of the LED pattern generator (PERIOD=8).
module tb_led_pattern_counter;
    typedef struct {
        logic       ld;
        logic [7:0] lv;
        logic [1:0] md;
        logic [1:0] sp;
        logic       en;
        int         n;
        logic [7:0] e_leds;
        logic       e_tick;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       load = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [1:0] speed = 2'b00;
    logic [7:0] load_value = 8'h00;
    logic [7:0] leds;
    logic       tick;
    int         checks = 0;
    int         errors = 0;
    vec_t       v[36];

    led_pattern_counter #(.CLK_FREQ(16), .TICK_HZ(2), .LED_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .speed(speed),
        .load(load), .load_value(load_value), .leds(leds), .tick(tick)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic ld, logic [7:0] lv, logic [1:0] md, logic [1:0] sp,
                                logic e, int n, logic [7:0] el, logic et);
        vec_t r;
        r.ld = ld; r.lv = lv; r.md = md; r.sp = sp; r.en = e; r.n = n; r.e_leds = el; r.e_tick = et;
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            load = v[i].ld; load_value = v[i].lv; mode = v[i].md; speed = v[i].sp; en = v[i].en;
            step(v[i].n);
            check($sformatf("vec%0d leds", i), leds, v[i].e_leds);
            check($sformatf("vec%0d tick", i), {7'b0, tick}, {7'b0, v[i].e_tick});
        end
    endtask

    initial begin
        logic [7:0] scan[15];
        int n80, n01;
        // binary up from reset, wrap, then binary down and Gray
        v[0]  = mk(0, 8'h00, 2'd0, 2'd0, 1, 7,    8'h00, 0);
        v[1]  = mk(0, 8'h00, 2'd0, 2'd0, 1, 1,    8'h01, 1);
        v[2]  = mk(0, 8'h00, 2'd0, 2'd0, 1, 1,    8'h01, 0);
        v[3]  = mk(0, 8'h00, 2'd0, 2'd0, 1, 7,    8'h02, 1);
        v[4]  = mk(0, 8'h00, 2'd0, 2'd0, 1, 2024, 8'hFF, 1);
        v[5]  = mk(0, 8'h00, 2'd0, 2'd0, 1, 8,    8'h00, 1);
        v[6]  = mk(0, 8'h00, 2'd0, 2'd0, 1, 40,   8'h05, 1);
        v[7]  = mk(0, 8'h00, 2'd1, 2'd0, 1, 1,    8'h00, 0);
        v[8]  = mk(0, 8'h00, 2'd1, 2'd0, 1, 7,    8'h00, 0);
        v[9]  = mk(0, 8'h00, 2'd1, 2'd0, 1, 1,    8'hFF, 1);
        v[10] = mk(0, 8'h00, 2'd1, 2'd0, 1, 8,    8'hFE, 1);
        v[11] = mk(0, 8'h00, 2'd2, 2'd0, 1, 1,    8'h00, 0);
        v[12] = mk(0, 8'h00, 2'd2, 2'd0, 1, 8,    8'h01, 1);
        v[13] = mk(0, 8'h00, 2'd2, 2'd0, 1, 8,    8'h03, 1);
        v[14] = mk(0, 8'h00, 2'd2, 2'd0, 1, 8,    8'h02, 1);
        v[15] = mk(0, 8'h00, 2'd2, 2'd0, 1, 8,    8'h06, 1);
        v[16] = mk(0, 8'h00, 2'd2, 2'd0, 1, 8,    8'h07, 1);
        v[17] = mk(0, 8'h00, 2'd2, 2'd0, 1, 8,    8'h05, 1);
        v[18] = mk(0, 8'h00, 2'd2, 2'd0, 1, 8,    8'h04, 1);
        v[19] = mk(0, 8'h00, 2'd3, 2'd0, 1, 1,    8'h01, 0);
        // speed: EFF=1, then jump from prescaler=6 to EFF=2
        v[20] = mk(0, 8'h00, 2'd0, 2'd3, 1, 1,    8'h00, 0);
        v[21] = mk(0, 8'h00, 2'd0, 2'd3, 1, 1,    8'h01, 1);
        v[22] = mk(0, 8'h00, 2'd0, 2'd3, 1, 1,    8'h02, 1);
        v[23] = mk(0, 8'h00, 2'd0, 2'd3, 1, 1,    8'h03, 1);
        v[24] = mk(0, 8'h00, 2'd0, 2'd0, 1, 6,    8'h03, 0);
        v[25] = mk(0, 8'h00, 2'd0, 2'd2, 1, 1,    8'h04, 1);
        v[26] = mk(0, 8'h00, 2'd0, 2'd2, 1, 1,    8'h04, 0);
        v[27] = mk(0, 8'h00, 2'd0, 2'd2, 1, 1,    8'h05, 1);
        // after freeze, then loads (including load while disabled)
        v[28] = mk(0, 8'h00, 2'd0, 2'd2, 1, 1,    8'h05, 0);
        v[29] = mk(0, 8'h00, 2'd0, 2'd2, 1, 1,    8'h06, 1);
        v[30] = mk(1, 8'hA5, 2'd0, 2'd0, 1, 1,    8'hA5, 0);
        v[31] = mk(0, 8'h00, 2'd0, 2'd0, 1, 7,    8'hA5, 0);
        v[32] = mk(0, 8'h00, 2'd0, 2'd0, 1, 1,    8'hA6, 1);
        v[33] = mk(1, 8'h3C, 2'd0, 2'd0, 0, 1,    8'h3C, 0);
        v[34] = mk(0, 8'h00, 2'd0, 2'd0, 0, 5,    8'h3C, 0);
        v[35] = mk(0, 8'h00, 2'd0, 2'd0, 1, 1,    8'h3C, 0);
        scan = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

        #3;
        check("reset leds", leds, 8'h00);
        check("reset tick", {7'b0, tick}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(0, 19);

        n80 = 0;
        n01 = 0;
        for (int i = 0; i < 15; i++) begin
            step(8);
            check($sformatf("scan%0d leds", i), leds, scan[i]);
            check($sformatf("scan%0d tick", i), {7'b0, tick}, 8'h01);
            if (i < 14 && leds == 8'h80) n80++;
            if (i < 14 && leds == 8'h01) n01++;
        end
        check("scan end 0x80 count", 8'(n80), 8'd1);
        check("scan end 0x01 count", 8'(n01), 8'd1);

        run(20, 27);

        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check($sformatf("freeze%0d leds", i), leds, 8'h05);
            check($sformatf("freeze%0d tick", i), {7'b0, tick}, 8'h00);
        end

        run(28, 35);

        #2;
        rst_n = 1'b0;
        #1;
        check("async reset leds", leds, 8'h00);
        check("async reset tick", {7'b0, tick}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(7);
        check("post reset leds", leds, 8'h00);
        step(1);
        check("post reset tick leds", leds, 8'h01);
        check("post reset tick", {7'b0, tick}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
